// File: rtl/mem_write_checker.sv
// Passive store monitor: checks CPU stores against an ordered (adr,data) table, sticky pass/fail, 1-edge status latency.
// No backpressure (drives nothing in the CPU). Optional MWC_XCHECK_EN adds X/Z detection and status messages.
module mem_write_checker #(
  parameter int                         XLEN       = 32,
  parameter int                         NUM_CHECKS = 1,
  parameter logic [NUM_CHECKS*XLEN-1:0] EXP_ADR    = {32'd100},
  parameter logic [NUM_CHECKS*XLEN-1:0] EXP_DATA   = {32'd25},
  parameter logic [XLEN-1:0]            IGN_LO     = 32'd96,
  parameter logic [XLEN-1:0]            IGN_HI     = 32'd96,
  parameter int                         TIMEOUT    = 1000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              MemWrite,
  input  logic [XLEN-1:0]                   DataAdr,
  input  logic [XLEN-1:0]                   WriteData,
  output logic                              done,
  output logic                              pass,
  output logic                              fail,
  output logic [1:0]                        fail_code,
  output logic [$clog2(NUM_CHECKS+1)-1:0]   match_cnt,
  output logic [15:0]                       write_cnt,
  output logic [XLEN-1:0]                   fail_adr,
  output logic [XLEN-1:0]                   fail_data
);

  localparam int CW = $clog2(NUM_CHECKS+1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;

  state_t          state;
  logic [31:0]     cyc_cnt;
  logic [XLEN-1:0] exp_adr_cur;
  logic [XLEN-1:0] exp_data_cur;
  logic            hit;
  logic            in_win;
  logic            last;
  logic            tmo;
  logic            xbad;
  logic [15:0]     wcnt_nxt;

  // Table entry selected by how many entries have matched so far.
  always_comb begin
    exp_adr_cur  = '0;
    exp_data_cur = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (int'(match_cnt) == i) begin
        exp_adr_cur  = EXP_ADR[i*XLEN +: XLEN];
        exp_data_cur = EXP_DATA[i*XLEN +: XLEN];
      end
    end
  end

  assign hit      = (DataAdr == exp_adr_cur) && (WriteData == exp_data_cur);
  assign in_win   = (DataAdr >= IGN_LO) && (DataAdr <= IGN_HI);
  assign last     = (int'(match_cnt) == NUM_CHECKS - 1);
  assign tmo      = (TIMEOUT != 0) && (cyc_cnt == 32'(TIMEOUT - 1));
  assign wcnt_nxt = (write_cnt == 16'hFFFF) ? write_cnt : write_cnt + 16'd1;

`ifdef MWC_XCHECK_EN
  assign xbad = $isunknown(MemWrite) ||
                ((MemWrite === 1'b1) && ($isunknown(DataAdr) || $isunknown(WriteData)));
`else
  assign xbad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      cyc_cnt   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      match_cnt <= '0;
      write_cnt <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (state == S_RUN) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (xbad) begin
        state     <= S_FAIL;
        fail      <= 1'b1;
        done      <= 1'b1;
        fail_code <= 2'd3;
        fail_adr  <= DataAdr;
        fail_data <= WriteData;
      end else if (MemWrite && hit) begin
        write_cnt <= wcnt_nxt;
        match_cnt <= match_cnt + CW'(1);
        // A final match wins over a timeout on the same edge.
        if (last) begin
          state <= S_PASS;
          pass  <= 1'b1;
          done  <= 1'b1;
        end else if (tmo) begin
          state     <= S_FAIL;
          fail      <= 1'b1;
          done      <= 1'b1;
          fail_code <= 2'd2;
        end
      end else if (MemWrite && in_win) begin
        write_cnt <= wcnt_nxt;
        if (tmo) begin
          state     <= S_FAIL;
          fail      <= 1'b1;
          done      <= 1'b1;
          fail_code <= 2'd2;
        end
      end else if (MemWrite) begin
        write_cnt <= wcnt_nxt;
        state     <= S_FAIL;
        fail      <= 1'b1;
        done      <= 1'b1;
        fail_code <= 2'd1;
        fail_adr  <= DataAdr;
        fail_data <= WriteData;
      end else if (tmo) begin
        state     <= S_FAIL;
        fail      <= 1'b1;
        done      <= 1'b1;
        fail_code <= 2'd2;
      end
    end
  end

`ifdef MWC_XCHECK_EN
  logic done_q;
  always_ff @(posedge clk) begin
    done_q <= reset ? 1'b0 : done;
    if (!reset && done && !done_q) begin
      if (pass) $display("Simulation succeeded");
      else      $display("Simulation failed: code=%0d adr=%h data=%h", fail_code, fail_adr, fail_data);
    end
  end
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: three checker instances (default table, two-entry table, short timeout) sharing one store bus.
module tb_mem_write_checker;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic [1:0]  match;
    logic [15:0] wcnt;
    logic [31:0] fadr;
    logic [31:0] fdat;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        mw;
    logic [31:0] adr;
    logic [31:0] dat;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_def = 1'b1, rst_two = 1'b1, rst_to = 1'b1;
  logic        mw = 1'b0;
  logic [31:0] adr = '0, dat = '0;

  logic        done_w [3];
  logic        pass_w [3];
  logic        fail_w [3];
  logic [1:0]  code_w [3];
  logic [1:0]  match_w[3];
  logic [15:0] wcnt_w [3];
  logic [31:0] fadr_w [3];
  logic [31:0] fdat_w [3];
  logic        match_def;
  logic        match_to;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign match_w[0] = {1'b0, match_def};
  assign match_w[2] = {1'b0, match_to};

  mem_write_checker u_def (
    .clk(clk), .reset(rst_def), .MemWrite(mw), .DataAdr(adr), .WriteData(dat),
    .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .fail_code(code_w[0]),
    .match_cnt(match_def), .write_cnt(wcnt_w[0]), .fail_adr(fadr_w[0]), .fail_data(fdat_w[0])
  );

  mem_write_checker #(
    .NUM_CHECKS(2), .EXP_ADR({32'd104, 32'd100}), .EXP_DATA({32'd7, 32'd25})
  ) u_two (
    .clk(clk), .reset(rst_two), .MemWrite(mw), .DataAdr(adr), .WriteData(dat),
    .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .fail_code(code_w[1]),
    .match_cnt(match_w[1]), .write_cnt(wcnt_w[1]), .fail_adr(fadr_w[1]), .fail_data(fdat_w[1])
  );

  mem_write_checker #(.TIMEOUT(50)) u_to (
    .clk(clk), .reset(rst_to), .MemWrite(mw), .DataAdr(adr), .WriteData(dat),
    .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .fail_code(code_w[2]),
    .match_cnt(match_to), .write_cnt(wcnt_w[2]), .fail_adr(fadr_w[2]), .fail_data(fdat_w[2])
  );

  function automatic out_t get(input int s);
    out_t o;
    o.done  = done_w[s];
    o.pass  = pass_w[s];
    o.fail  = fail_w[s];
    o.code  = code_w[s];
    o.match = match_w[s];
    o.wcnt  = wcnt_w[s];
    o.fadr  = fadr_w[s];
    o.fdat  = fdat_w[s];
    return o;
  endfunction

  function automatic out_t mk(input logic dn, ps, fl, input logic [1:0] cd, mc,
                              input logic [15:0] wc, input logic [31:0] fa, fd);
    out_t o;
    o.done = dn; o.pass = ps; o.fail = fl; o.code = cd;
    o.match = mc; o.wcnt = wc; o.fadr = fa; o.fdat = fd;
    return o;
  endfunction

  function automatic vec_t vv(input logic r, m, input logic [31:0] a, d, input out_t e);
    vec_t v;
    v.rst = r; v.mw = m; v.adr = a; v.dat = d; v.exp = e;
    return v;
  endfunction

  // Drive on the falling edge, let the target see one rising edge, sample 1 ns later.
  task automatic step(input int s, input logic r, m, input logic [31:0] a, d);
    @(negedge clk);
    rst_def = (s == 0) ? r : 1'b1;
    rst_two = (s == 1) ? r : 1'b1;
    rst_to  = (s == 2) ? r : 1'b1;
    mw  = m;
    adr = a;
    dat = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int s, input out_t e);
    out_t g;
    g = get(s);
    nchk++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got done=%0d pass=%0d fail=%0d code=%0d match=%0d wcnt=%0d adr=%0d data=%0d, want done=%0d pass=%0d fail=%0d code=%0d match=%0d wcnt=%0d adr=%0d data=%0d",
               nm, g.done, g.pass, g.fail, g.code, g.match, g.wcnt, g.fadr, g.fdat,
               e.done, e.pass, e.fail, e.code, e.match, e.wcnt, e.fadr, e.fdat);
    end
  endtask

  vec_t        tab[$];
  out_t        zero;
  out_t        got;
  logic [31:0] xv;

  initial begin
    zero = '0;

    // ---- Default table instance ----
    tab.push_back(vv(1, 0,   0,  0, zero));
    tab.push_back(vv(0, 0, 100, 25, zero));
    tab.push_back(vv(0, 1,  96,  5, mk(0,0,0,0,0,1,0,0)));
    tab.push_back(vv(0, 1, 100, 25, mk(1,1,0,0,1,2,0,0)));
    tab.push_back(vv(0, 1, 100, 24, mk(1,1,0,0,1,2,0,0)));
    tab.push_back(vv(1, 0,   0,  0, zero));
    tab.push_back(vv(0, 1,  96,  5, mk(0,0,0,0,0,1,0,0)));
    tab.push_back(vv(0, 1, 100, 25, mk(1,1,0,0,1,2,0,0)));
    tab.push_back(vv(1, 0,   0,  0, zero));
    tab.push_back(vv(0, 1, 100, 24, mk(1,0,1,1,0,1,100,24)));
    tab.push_back(vv(0, 1, 100, 25, mk(1,0,1,1,0,1,100,24)));
    tab.push_back(vv(0, 0,   0,  0, mk(1,0,1,1,0,1,100,24)));
    tab.push_back(vv(1, 0,   0,  0, zero));
    tab.push_back(vv(0, 1,  97, 25, mk(1,0,1,1,0,1,97,25)));
    tab.push_back(vv(1, 0,   0,  0, zero));
    tab.push_back(vv(0, 1,  95, 25, mk(1,0,1,1,0,1,95,25)));
    tab.push_back(vv(1, 0,   0,  0, zero));
    tab.push_back(vv(0, 1, 100, 25, mk(1,1,0,0,1,1,0,0)));

    foreach (tab[i]) begin
      step(0, tab[i].rst, tab[i].mw, tab[i].adr, tab[i].dat);
      chk($sformatf("def_vec%0d", i), 0, tab[i].exp);
    end

    // Unknown address on a store never produces code 3 in the default build.
    step(0, 1, 0, 0, 0);
    xv = 'x;
    step(0, 0, 1, xv, 32'd99);
    got = get(0);
    nchk++;
    if (got.code === 2'd3 || got.fail !== 1'b1) begin
      nerr++;
      $display("FAIL def_xstore: got fail=%0d code=%0d, want fail=1 code!=3", got.fail, got.code);
    end

    // ---- Two-entry table ----
    step(1, 1, 0, 0, 0);
    chk("two_reset", 1, zero);
    step(1, 0, 1, 100, 25);
    chk("two_first", 1, mk(0,0,0,0,1,1,0,0));
    step(1, 0, 1, 104, 7);
    chk("two_pass", 1, mk(1,1,0,0,2,2,0,0));
    step(1, 1, 0, 0, 0);
    chk("two_reset2", 1, zero);
    step(1, 0, 1, 104, 7);
    chk("two_order", 1, mk(1,0,1,1,0,1,104,7));

    // ---- Timeout instance: fail exactly on the 50th edge after release ----
    step(2, 1, 0, 0, 0);
    chk("to_reset", 2, zero);
    for (int k = 1; k <= 49; k++) begin
      step(2, 0, 0, 0, 0);
      if (k == 1 || k == 49) chk($sformatf("to_idle%0d", k), 2, zero);
    end
    step(2, 0, 0, 0, 0);
    chk("to_expire", 2, mk(1,0,1,2,0,0,0,0));
    step(2, 0, 1, 100, 25);
    chk("to_frozen", 2, mk(1,0,1,2,0,0,0,0));

    // Final match on the timeout edge wins.
    step(2, 1, 0, 0, 0);
    for (int k = 1; k <= 49; k++) step(2, 0, 0, 0, 0);
    chk("race_pre", 2, zero);
    step(2, 0, 1, 100, 25);
    chk("race_pass", 2, mk(1,1,0,0,1,1,0,0));

    // Window store on the timeout edge still times out.
    step(2, 1, 0, 0, 0);
    for (int k = 1; k <= 49; k++) step(2, 0, 0, 0, 0);
    step(2, 0, 1, 96, 3);
    chk("race_window", 2, mk(1,0,1,2,0,1,0,0));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
